// File: rtl/i2s_receiver.sv
// I2S capture: oversampled SCLK/LRCLK/SDIN deserialised into left/right PCM pairs over valid/ready.
// Optional bar-graph peak meter on the left channel when PEAK_METER_EN is defined.
module i2s_receiver #(
    parameter int DATA_W      = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic              Clk,
    input  logic              Reset,
`ifdef PEAK_METER_EN
    input  logic              Peak_Clear,
    output logic [9:0]        Peak_Level,
`endif
    input  logic              SCLK,
    input  logic              LRCLK,
    input  logic              SDIN,
    input  logic              Ready,
    output logic [DATA_W-1:0] Left_Sample,
    output logic [DATA_W-1:0] Right_Sample,
    output logic              Valid,
    output logic              Overrun,
    output logic              Frame_Err
);

    localparam int CNT_W = $clog2(DATA_W + 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_WAIT
    } state_t;

    logic [SYNC_STAGES-1:0] r_sclk_sync;
    logic [SYNC_STAGES-1:0] r_ws_sync;
    logic [SYNC_STAGES-1:0] r_sd_sync;
    logic                   r_sclk_hist;

    state_t                 r_state;
    logic                   r_ws_prev;
    logic                   r_cur_ch;
    logic [CNT_W-1:0]       r_bit_cnt;
    logic [DATA_W-1:0]      r_shift;
    logic [DATA_W-1:0]      r_left_buf;
    logic [DATA_W-1:0]      r_right_buf;
    logic                   r_have_left;
    logic                   r_pair_done;

    logic                   w_sclk_rise;
    logic                   w_ws;
    logic                   w_bit;
    logic                   w_ws_edge;
    logic [DATA_W-1:0]      w_next_word;
    logic [CNT_W-1:0]       w_cnt_next;
    logic                   w_commit;

    assign w_sclk_rise = r_sclk_sync[SYNC_STAGES-1] & ~r_sclk_hist;
    assign w_ws        = r_ws_sync[SYNC_STAGES-1];
    assign w_bit       = r_sd_sync[SYNC_STAGES-1];
    assign w_ws_edge   = w_ws ^ r_ws_prev;
    assign w_next_word = {r_shift[DATA_W-2:0], w_bit};
    assign w_cnt_next  = r_bit_cnt + 1'b1;
    assign w_commit    = r_pair_done & (~Valid | Ready);

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_sclk_sync <= '0;
            r_ws_sync   <= '0;
            r_sd_sync   <= '0;
            r_sclk_hist <= 1'b0;
        end else begin
            r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], SCLK};
            r_ws_sync   <= {r_ws_sync[SYNC_STAGES-2:0], LRCLK};
            r_sd_sync   <= {r_sd_sync[SYNC_STAGES-2:0], SDIN};
            r_sclk_hist <= r_sclk_sync[SYNC_STAGES-1];
        end
    end

    // The sclk_rise carrying a ws change still holds the previous slot's LSB,
    // so it only restarts the slot; the MSB is shifted on the following rise.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state     <= ST_IDLE;
            r_ws_prev   <= 1'b0;
            r_cur_ch    <= 1'b0;
            r_bit_cnt   <= '0;
            r_shift     <= '0;
            r_left_buf  <= '0;
            r_right_buf <= '0;
            r_have_left <= 1'b0;
            r_pair_done <= 1'b0;
            Frame_Err   <= 1'b0;
        end else begin
            r_pair_done <= 1'b0;
            Frame_Err   <= 1'b0;
            if (w_sclk_rise) begin
                r_ws_prev <= w_ws;
                case (r_state)
                    ST_IDLE, ST_WAIT: begin
                        if (w_ws_edge) begin
                            r_state   <= ST_SHIFT;
                            r_cur_ch  <= w_ws;
                            r_bit_cnt <= '0;
                            r_shift   <= '0;
                        end
                    end
                    ST_SHIFT: begin
                        if (w_ws_edge) begin
                            Frame_Err   <= 1'b1;
                            r_have_left <= 1'b0;
                            r_cur_ch    <= w_ws;
                            r_bit_cnt   <= '0;
                            r_shift     <= '0;
                        end else begin
                            r_shift   <= w_next_word;
                            r_bit_cnt <= w_cnt_next;
                            if (w_cnt_next == CNT_W'(DATA_W)) begin
                                r_state <= ST_WAIT;
                                if (!r_cur_ch) begin
                                    r_left_buf  <= w_next_word;
                                    r_have_left <= 1'b1;
                                end else if (r_have_left) begin
                                    r_right_buf <= w_next_word;
                                    r_have_left <= 1'b0;
                                    r_pair_done <= 1'b1;
                                end
                            end
                        end
                    end
                    default: r_state <= ST_IDLE;
                endcase
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            Left_Sample  <= '0;
            Right_Sample <= '0;
            Valid        <= 1'b0;
            Overrun      <= 1'b0;
        end else if (r_pair_done) begin
            if (w_commit) begin
                Left_Sample  <= r_left_buf;
                Right_Sample <= r_right_buf;
                Valid        <= 1'b1;
            end else begin
                Overrun <= 1'b1;
            end
        end else if (Valid && Ready) begin
            Valid <= 1'b0;
        end
    end

`ifdef PEAK_METER_EN
    logic [DATA_W-1:0] w_mag;
    logic [9:0]        w_lvl;

    // Most-negative input saturates so the magnitude stays representable.
    always_comb begin
        w_mag = r_left_buf;
        if (r_left_buf[DATA_W-1]) begin
            if (r_left_buf == {1'b1, {(DATA_W-1){1'b0}}})
                w_mag = {1'b0, {(DATA_W-1){1'b1}}};
            else
                w_mag = ~r_left_buf + 1'b1;
        end
        w_lvl = '0;
        for (int unsigned k = 0; k < 10; k++)
            w_lvl[k] = (w_mag >> (DATA_W - 11 + k)) != '0;
    end

    always_ff @(posedge Clk) begin
        if (Reset)
            Peak_Level <= '0;
        else if (Peak_Clear)
            Peak_Level <= '0;
        else if (w_commit)
            Peak_Level <= Peak_Level | w_lvl;
    end
`endif

endmodule

// File: tb/tb_i2s_receiver.sv
// Directed-stimulus bench for i2s_receiver: slot-level behavioural model plus literal checks.
`timescale 1ns/1ps
module tb_i2s_receiver;
    localparam int DW   = 16;
    localparam int SS   = 2;
    localparam int HALF = 8;

    logic          Clk = 1'b0;
    logic          Reset, SCLK, LRCLK, SDIN, Ready;
    logic [DW-1:0] Left_Sample, Right_Sample;
    logic          Valid, Overrun, Frame_Err;
`ifdef PEAK_METER_EN
    logic          Peak_Clear;
    logic [9:0]    Peak_Level;
`endif

    i2s_receiver #(.DATA_W(DW), .SYNC_STAGES(SS)) dut (
        .Clk          (Clk),
        .Reset        (Reset),
`ifdef PEAK_METER_EN
        .Peak_Clear   (Peak_Clear),
        .Peak_Level   (Peak_Level),
`endif
        .SCLK         (SCLK),
        .LRCLK        (LRCLK),
        .SDIN         (SDIN),
        .Ready        (Ready),
        .Left_Sample  (Left_Sample),
        .Right_Sample (Right_Sample),
        .Valid        (Valid),
        .Overrun      (Overrun),
        .Frame_Err    (Frame_Err)
    );

    always #5 Clk = ~Clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct {
        int unsigned   due;
        bit            is_pair;
        logic [DW-1:0] l;
        logic [DW-1:0] r;
    } ev_t;

    int unsigned   cyc = 0;
    ev_t           evq[$];
    ev_t           ev;
    bit            m_pin_prev, m_locked, m_ws_prev, m_ch, m_left_ok, m_pair;
    int            m_nbits;
    logic [DW-1:0] m_acc, m_left, m_pl, m_pr;
    logic [DW-1:0] exp_l, exp_r;
    bit            exp_v, exp_ovr, exp_ferr;
    logic [9:0]    exp_peak;

    function automatic logic [9:0] meter(input logic [DW-1:0] l);
        int s;
        int mag;
        logic [9:0] t;
        s   = int'($signed(l));
        mag = (s < 0) ? -s : s;
        if (mag > 32767) mag = 32767;
        for (int k = 0; k < 10; k++) t[k] = (mag >= (1 << (DW - 11 + k)));
        return t;
    endfunction

    // A slot opens on every ws change; its first DW bits after the change form the word.
    // Pin rise at cycle N: error visible after edge N+3, pair committed at edge N+4.
    task automatic model_bit(input bit ws, input bit d);
        bit chg;
        chg = (ws != m_ws_prev);
        m_ws_prev = ws;
        if (chg) begin
            if (m_locked && m_nbits < DW) begin
                evq.push_back('{cyc + 2, 1'b0, '0, '0});
                m_left_ok = 0;
            end
            m_locked = 1;
            m_ch     = ws;
            m_nbits  = 0;
            m_acc    = '0;
        end else if (m_locked && m_nbits < DW) begin
            m_acc = {m_acc[DW-2:0], d};
            m_nbits++;
            if (m_nbits == DW) begin
                if (!m_ch) begin
                    m_left    = m_acc;
                    m_left_ok = 1;
                end else if (m_left_ok) begin
                    evq.push_back('{cyc + 3, 1'b1, m_left, m_acc});
                    m_left_ok = 0;
                end
            end
        end
    endtask

    always @(posedge Clk) begin
        cyc++;
        exp_ferr = 0;
        if (Reset) begin
            evq.delete();
            exp_l = '0; exp_r = '0; exp_v = 0; exp_ovr = 0; exp_peak = '0;
            m_locked = 0; m_ws_prev = 0; m_left_ok = 0; m_nbits = 0; m_acc = '0;
        end else begin
            if (SCLK && !m_pin_prev) model_bit(LRCLK, SDIN);
            m_pair = 0;
            while (evq.size() > 0 && evq[0].due <= cyc) begin
                ev = evq.pop_front();
                if (ev.is_pair) begin
                    m_pair = 1; m_pl = ev.l; m_pr = ev.r;
                end else begin
                    exp_ferr = 1;
                end
            end
            if (m_pair) begin
                if (!exp_v || Ready) begin
                    exp_l = m_pl; exp_r = m_pr; exp_v = 1;
`ifdef PEAK_METER_EN
                    exp_peak = exp_peak | meter(m_pl);
`endif
                end else begin
                    exp_ovr = 1;
                end
            end else if (exp_v && Ready) begin
                exp_v = 0;
            end
`ifdef PEAK_METER_EN
            if (Peak_Clear) exp_peak = '0;
`endif
        end
        m_pin_prev = SCLK;
    end

    // ---------------- per-cycle compare + event monitor ----------------
    bit          v_prev = 0;
    int          v_rises = 0, v_hi = 0, ferr_cnt = 0;
    int unsigned v_rise_cyc = 0;
    logic [DW-1:0] v_rise_l, v_rise_r;

    always @(negedge Clk) begin
        check("valid",     Valid,        exp_v);
        check("left",      Left_Sample,  exp_l);
        check("right",     Right_Sample, exp_r);
        check("overrun",   Overrun,      exp_ovr);
        check("frame_err", Frame_Err,    exp_ferr);
`ifdef PEAK_METER_EN
        check("peak",      Peak_Level,   exp_peak);
`endif
        if (Valid && !v_prev) begin
            v_rises++;
            v_rise_cyc = cyc;
            v_rise_l   = Left_Sample;
            v_rise_r   = Right_Sample;
            v_hi       = 0;
        end
        if (Valid) v_hi++;
        if (Frame_Err) ferr_cnt++;
        v_prev = Valid;
    end

    // ---------------- stimulus ----------------
    bit          last_bit = 0;
    int unsigned last_rise_cyc = 0;
    int unsigned lsb_cyc = 0;

    function automatic bit data_bit(input logic [DW-1:0] w, input int j);
        return (j >= 0 && j < DW) ? w[DW-1-j] : 1'b0;
    endfunction

    task automatic sclk_bit(input bit ws, input bit d);
        LRCLK = ws;
        SDIN  = d;
        repeat (HALF) @(posedge Clk);
        #1 SCLK = 1'b1;
        last_rise_cyc = cyc;
        repeat (HALF) @(posedge Clk);
        #1 SCLK = 1'b0;
    endtask

    task automatic send_slot(input bit ws, input logic [DW-1:0] w, input int n);
        for (int i = 0; i < n; i++) begin
            sclk_bit(ws, (i == 0) ? last_bit : data_bit(w, i - 1));
            if (ws && i == DW) lsb_cyc = last_rise_cyc;
        end
        last_bit = data_bit(w, n - 1);
    endtask

    task automatic send_frame(input logic [DW-1:0] l, input logic [DW-1:0] r);
        send_slot(1'b0, l, 32);
        send_slot(1'b1, r, 32);
    endtask

    task automatic do_reset();
        @(posedge Clk);
        #1 Reset = 1'b1;
        repeat (2) @(posedge Clk);
        #1 Reset = 1'b0;
    endtask

    int v0, f0;

    initial begin
        Reset = 1'b1; SCLK = 1'b0; LRCLK = 1'b0; SDIN = 1'b0; Ready = 1'b1;
`ifdef PEAK_METER_EN
        Peak_Clear = 1'b0;
`endif
        repeat (3) @(posedge Clk);
        #1 Reset = 1'b0;
        check("reset_valid",   Valid,        1'b0);
        check("reset_left",    Left_Sample,  16'h0000);
        check("reset_overrun", Overrun,      1'b0);

        // 1: single pair, Ready high
        f0 = ferr_cnt;
        send_slot(1'b1, 16'h0000, 32);
        send_frame(16'hA5C3, 16'h0F0F);
        repeat (4) @(posedge Clk);
        check("t1_left",    v_rise_l, 16'hA5C3);
        check("t1_right",   v_rise_r, 16'h0F0F);
        check("t1_latency", v_rise_cyc - lsb_cyc, SS + 2);
        check("t1_pulse",   v_hi, 1);
        check("t1_noerr",   ferr_cnt - f0, 0);

        // 2: back-pressure and overrun
        #1 Ready = 1'b0;
        send_frame(16'h1234, 16'h5678);
        send_frame(16'h9ABC, 16'hDEF0);
        repeat (4) @(posedge Clk);
        #1;
        check("t2_left",    Left_Sample,  16'h1234);
        check("t2_right",   Right_Sample, 16'h5678);
        check("t2_valid",   Valid,        1'b1);
        check("t2_overrun", Overrun,      1'b1);
        Ready = 1'b1;
        @(negedge Clk);
        check("t2_hold",    Valid, 1'b1);
        @(posedge Clk);
        #1 check("t2_fall", Valid, 1'b0);

        // 3: stream begins mid-left slot after reset
        do_reset();
        v0 = v_rises;
        send_slot(1'b0, 16'hFFFF, 20);
        send_slot(1'b1, 16'h1111, 32);
        send_frame(16'h1357, 16'hECA8);
        repeat (4) @(posedge Clk);
        check("t3_pairs", v_rises - v0, 1);
        check("t3_left",  v_rise_l, 16'h1357);
        check("t3_right", v_rise_r, 16'hECA8);

        // 4: truncated left slot
        f0 = ferr_cnt;
        v0 = v_rises;
        send_slot(1'b0, 16'hBEEF, 10);
        send_slot(1'b1, 16'h2222, 32);
        send_frame(16'h4321, 16'h8765);
        repeat (4) @(posedge Clk);
        check("t4_ferr",  ferr_cnt - f0, 1);
        check("t4_pairs", v_rises - v0, 1);
        check("t4_left",  v_rise_l, 16'h4321);
        check("t4_right", v_rise_r, 16'h8765);

        // 5: reset during the right slot
        send_slot(1'b0, 16'h7E81, 32);
        send_slot(1'b1, 16'h55AA, 8);
        do_reset();
        check("t5_left",    Left_Sample,  16'h0000);
        check("t5_right",   Right_Sample, 16'h0000);
        check("t5_valid",   Valid,        1'b0);
        check("t5_overrun", Overrun,      1'b0);
        v0 = v_rises;
        send_slot(1'b1, 16'h0000, 24);
        send_frame(16'hC0DE, 16'h0BAD);
        repeat (4) @(posedge Clk);
        check("t5_pairs", v_rises - v0, 1);
        check("t5_left",  v_rise_l, 16'hC0DE);
        check("t5_right", v_rise_r, 16'h0BAD);

`ifdef PEAK_METER_EN
        // 6: peak meter
        do_reset();
        send_slot(1'b1, 16'h0000, 32);
        send_frame(16'h8000, 16'h0001);
        #1 check("t6_full", Peak_Level, 10'h3FF);
        @(posedge Clk);
        #1 Peak_Clear = 1'b1;
        @(posedge Clk);
        #1 Peak_Clear = 1'b0;
        check("t6_clear", Peak_Level, 10'h000);
        send_frame(16'h0400, 16'h0000);
        #1 check("t6_mid", Peak_Level, meter(16'h0400));
`endif

        repeat (10) @(posedge Clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
